// File: rtl/adc_fifo_writer_if.sv
// rtl/adc_fifo_writer_if.sv - Avalon-style write bus between adc_fifo_writer and a system FIFO sink
//
// Signals:
//   writedata    32  word offered to the sink
//   write         1  writedata is valid this cycle
//   waitrequest   1  sink stall; the master holds writedata/write while high
// Modports:
//   master  drives writedata/write, samples waitrequest (adc_fifo_writer side)
//   slave   samples writedata/write, drives waitrequest (system FIFO side)

interface adc_fifo_writer_if;
   logic [31:0] writedata;
   logic        write;
   logic        waitrequest;

   modport master (output writedata, output write, input waitrequest);
   modport slave  (input writedata, input write, output waitrequest);
endinterface

// File: rtl/adc_fifo_writer.sv
// rtl/adc_fifo_writer.sv - ADC event builder: header/data/trailer framing into a system FIFO
//
// Captures NSAMP ADC samples per accepted trigger, packs them in pairs into 32-bit
// words, frames them as header / data / trailer and drains them through a local
// word buffer into the system FIFO with waitrequest flow control.
//
// Ports:
//   clk_clk        in   1      system clock
//   reset_reset_n  in   1      asynchronous active-low reset
//   ext_rst        in   1      synchronous soft clear, active high, highest priority
//   write_en       in   1      trigger enable
//   trig           in   1      external trigger level (synchronous to clk_clk)
//   adc_data       in   ADC_W  ADC sample
//   adc_valid      in   1      adc_data valid this cycle
//   fifo_in        master      writedata/write/waitrequest bus to the system FIFO
//   busy           out  1      event in capture, buffer non-empty or write pending
//   ovf            out  1      sticky overflow (cleared by reset or ext_rst only)
//   evt_cnt        out  16     accepted-event counter, wraps 0xFFFF -> 0

module adc_fifo_writer #(
   parameter int         ADC_W     = 12,
   parameter int         NSAMP     = 64,
   parameter int         BUF_DEPTH = 16,
   parameter logic [7:0] HDR_TAG   = 8'hA5,
   parameter logic [7:0] TRL_TAG   = 8'h5A
) (
   input  logic                clk_clk,
   input  logic                reset_reset_n,
   input  logic                ext_rst,
   input  logic                write_en,
   input  logic                trig,
   input  logic [ADC_W-1:0]    adc_data,
   input  logic                adc_valid,
   adc_fifo_writer_if.master   fifo_in,
   output logic                busy,
   output logic                ovf,
   output logic [15:0]         evt_cnt
);

   localparam int         AW       = $clog2(BUF_DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(BUF_DEPTH);
   localparam logic [15:0] NSAMP_W  = 16'(NSAMP);

   typedef enum logic [1:0] {S_IDLE, S_DATA, S_TRL} state_t;

   state_t            state;
   logic              trig_q;
   logic [15:0]       samp_cnt;
   logic [ADC_W-1:0]  even_q;
   logic              evt_ovf;

   logic [31:0]       mem [BUF_DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [AW:0]       count;
   logic [31:0]       out_data;
   logic              out_valid;

   logic              trig_edge;
   logic              push_req;
   logic [31:0]       push_word;
   logic              full;
   logic              empty;
   logic              push_ok;
   logic              accept;
   logic              pop;

   // Full/empty come from registered state only, so a push into a full buffer
   // is dropped even when a pop frees a slot in the same cycle.
   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign push_ok = push_req & ~full;
   assign accept  = out_valid & ~fifo_in.waitrequest;
   // Output register refills when empty or when its word leaves this cycle.
   assign pop     = ~empty & (~out_valid | accept);

   assign fifo_in.writedata = out_data;
   assign fifo_in.write     = out_valid;
   assign busy              = (state != S_IDLE) | ~empty | out_valid;

   always_comb begin
      trig_edge = trig & ~trig_q;
      push_req  = 1'b0;
      push_word = '0;
      case (state)
         S_IDLE: begin
            if (trig_edge && write_en) begin
               push_req  = 1'b1;
               push_word = {HDR_TAG, 8'h00, evt_cnt};
            end
         end
         S_DATA: begin
            // An odd-indexed sample completes a pair; the older sample goes low.
            if (adc_valid && samp_cnt[0]) begin
               push_req  = 1'b1;
               push_word = {16'(adc_data), 16'(even_q)};
            end
         end
         S_TRL: begin
            push_req  = 1'b1;
            push_word = {TRL_TAG, evt_ovf, 7'b0, NSAMP_W};
         end
         default: ;
      endcase
   end

   // Event FSM: header on accepted edge, sample pairing, trailer.
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         state    <= S_IDLE;
         trig_q   <= 1'b0;
         samp_cnt <= '0;
         even_q   <= '0;
         evt_ovf  <= 1'b0;
         ovf      <= 1'b0;
         evt_cnt  <= '0;
      end else if (ext_rst) begin
         state    <= S_IDLE;
         trig_q   <= 1'b0;
         samp_cnt <= '0;
         even_q   <= '0;
         evt_ovf  <= 1'b0;
         ovf      <= 1'b0;
         evt_cnt  <= '0;
      end else begin
         trig_q <= trig;
         case (state)
            S_IDLE: begin
               if (trig_edge && write_en) begin
                  if (!full) begin
                     evt_cnt  <= evt_cnt + 16'd1;
                     samp_cnt <= '0;
                     state    <= S_DATA;
                  end else begin
                     ovf <= 1'b1;
                  end
               end
            end
            S_DATA: begin
               if (adc_valid) begin
                  if (!samp_cnt[0]) begin
                     even_q <= adc_data;
                  end else if (full) begin
                     ovf     <= 1'b1;
                     evt_ovf <= 1'b1;
                  end
                  // Counting continues through drops so the event length is fixed.
                  samp_cnt <= samp_cnt + 16'd1;
                  if (samp_cnt == NSAMP_W - 16'd1) begin
                     state <= S_TRL;
                  end
               end
            end
            S_TRL: begin
               // The trailer waits for space rather than being dropped.
               if (!full) begin
                  evt_ovf <= 1'b0;
                  state   <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Buffer storage has no reset; validity is tracked by the pointers and count.
   always_ff @(posedge clk_clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= push_word;
      end
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
      end else if (ext_rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push_ok, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
         if (pop) begin
            out_data  <= mem[rd_ptr];
            out_valid <= 1'b1;
         end else if (accept) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_adc_fifo_writer.sv
// tb/tb_adc_fifo_writer.sv - randomized self-checking bench for adc_fifo_writer

module tb_adc_fifo_writer;
   localparam int ADC_W     = 12;
   localparam int NSAMP     = 12;
   localparam int BUF_DEPTH = 4;
   localparam int NW        = NSAMP / 2;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             ext_rst = 1'b0;
   logic             write_en = 1'b0;
   logic             trig = 1'b0;
   logic [ADC_W-1:0] adc_data = '0;
   logic             adc_valid = 1'b0;
   logic             busy;
   logic             ovf;
   logic [15:0]      evt_cnt;

   adc_fifo_writer_if fifo_in ();

   adc_fifo_writer #(
      .ADC_W(ADC_W), .NSAMP(NSAMP), .BUF_DEPTH(BUF_DEPTH),
      .HDR_TAG(8'hA5), .TRL_TAG(8'h5A)
   ) dut (
      .clk_clk(clk), .reset_reset_n(rst_n), .ext_rst(ext_rst), .write_en(write_en),
      .trig(trig), .adc_data(adc_data), .adc_valid(adc_valid), .fifo_in(fifo_in),
      .busy(busy), .ovf(ovf), .evt_cnt(evt_cnt)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, act, exp);
   endtask

   // Reference model state
   logic [ADC_W-1:0] smp [NSAMP];
   logic [15:0]      exp_cnt = '0;
   logic [15:0]      hdr_cnt = '0;
   logic             exp_ovf = 1'b0;

   function automatic logic [31:0] exp_word(input int j);
      return {4'b0, smp[2*j+1], 4'b0, smp[2*j]};
   endfunction

   // Sink: random or forced waitrequest
   int wr_pct      = 0;
   bit stall_force = 1'b0;
   initial begin
      fifo_in.waitrequest = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         fifo_in.waitrequest = stall_force || ($urandom_range(99) < wr_pct);
      end
   end

   // Monitor: collect accepted words, flag changes while stalled
   logic [31:0] got [$];
   int          stall_viol = 0;
   logic        prev_hold  = 1'b0;
   logic        prev_clr   = 1'b0;
   logic [31:0] prev_data  = '0;
   always @(negedge clk) begin
      if (prev_hold && !prev_clr && (!fifo_in.write || fifo_in.writedata !== prev_data))
         stall_viol++;
      if (fifo_in.write && !fifo_in.waitrequest) got.push_back(fifo_in.writedata);
      prev_hold = fifo_in.write && fifo_in.waitrequest;
      prev_data = fifo_in.writedata;
      prev_clr  = ext_rst || !rst_n;
   end

   task automatic wait_idle(input string tag);
      bit done = 1'b0;
      for (int k = 0; k < 2000 && !done; k++) begin
         @(negedge clk);
         if (!busy) done = 1'b1;
      end
      check(tag, done, 1'b1);
   endtask

   task automatic check_event(input int exact_data);
      int n;
      int j;
      int bad;
      logic drop;
      n = got.size();
      check("word_count_min", n >= 2, 1'b1);
      if (n >= 2) begin
         check("header", got[0], {8'hA5, 8'h00, hdr_cnt});
         drop = (n - 2) < NW;
         check("trailer", got[n-1], {8'h5A, drop, 7'b0, 16'(NSAMP)});
         j = 0;
         bad = 0;
         for (int k = 1; k < n - 1; k++) begin
            while (j < NW && got[k] != exp_word(j)) j++;
            if (j >= NW) bad++;
            else j++;
         end
         check("data_order", bad, 0);
         if (exact_data >= 0) begin
            check("data_count", n - 2, exact_data);
            for (int k = 0; k < exact_data && k < n - 2; k++)
               check("data_exact", got[1+k], exp_word(k));
         end
         if (drop) exp_ovf = 1'b1;
      end
      check("evt_cnt", evt_cnt, exp_cnt);
      check("ovf", ovf, exp_ovf);
      check("stall_stable", stall_viol, 0);
   endtask

   // One event: trigger, feed NSAMP samples, optionally hold a stall, then drain and check.
   task automatic run_event(input int valid_pct, input bit mid_trig, input int stall_cycles,
                            input int exact_data);
      got.delete();
      stall_viol = 0;
      if (stall_cycles > 0) begin
         stall_force = 1'b1;
         repeat (2) @(posedge clk);
      end
      @(posedge clk);
      #1;
      write_en = 1'b1;
      trig     = 1'b1;
      hdr_cnt  = exp_cnt;
      exp_cnt  = exp_cnt + 16'd1;
      @(posedge clk);
      #1;
      trig = 1'b0;
      for (int i = 0; i < NSAMP; ) begin
         if ($urandom_range(99) < valid_pct) begin
            adc_valid = 1'b1;
            adc_data  = smp[i];
            i++;
         end else begin
            adc_valid = 1'b0;
            adc_data  = ADC_W'($urandom);
         end
         trig = mid_trig && (i == 3);
         @(posedge clk);
         #1;
      end
      adc_valid = 1'b0;
      trig      = 1'b0;
      if (stall_cycles > 0) begin
         repeat (stall_cycles) @(posedge clk);
         @(negedge clk);
         check("stall_no_words", got.size(), 0);
         check("stall_busy", busy, 1'b1);
         check("stall_write", fifo_in.write, 1'b1);
         stall_force = 1'b0;
      end
      wait_idle("drain_timeout");
      check_event(exact_data);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_write", fifo_in.write, 1'b0);
      check("rst_data", fifo_in.writedata, 32'h0);
      check("rst_busy", busy, 1'b0);
      check("rst_ovf", ovf, 1'b0);
      check("rst_evt_cnt", evt_cnt, 16'h0);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);

      // Known samples, free-flowing sink
      for (int i = 0; i < NSAMP; i++) smp[i] = ADC_W'(i + 1);
      wr_pct = 0;
      run_event(100, 1'b0, 0, NW);

      // Random samples, valid gaps and sink stalls
      for (int e = 0; e < 10; e++) begin
         for (int i = 0; i < NSAMP; i++) smp[i] = ADC_W'($urandom);
         wr_pct = $urandom_range(50);
         run_event($urandom_range(40, 100), e[0], 0, -1);
      end

      // Trigger during capture is ignored
      wr_pct = 10;
      for (int i = 0; i < NSAMP; i++) smp[i] = ADC_W'($urandom);
      run_event(70, 1'b1, 0, -1);

      // Long stall: buffer fills, later data words drop, trailer survives
      wr_pct = 0;
      for (int i = 0; i < NSAMP; i++) smp[i] = ADC_W'($urandom);
      run_event(100, 1'b0, 60, BUF_DEPTH);
      check("stall_ovf_set", ovf, 1'b1);

      // Trigger with write_en low is ignored
      got.delete();
      @(posedge clk);
      #1;
      write_en = 1'b0;
      trig     = 1'b1;
      @(posedge clk);
      #1;
      trig = 1'b0;
      repeat (6) @(posedge clk);
      @(negedge clk);
      check("noen_evt_cnt", evt_cnt, exp_cnt);
      check("noen_busy", busy, 1'b0);
      check("noen_words", got.size(), 0);
      check("noen_ovf", ovf, exp_ovf);

      // Soft clear mid-event with a word stalled on the bus
      stall_force = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      write_en = 1'b1;
      trig     = 1'b1;
      @(posedge clk);
      #1;
      trig = 1'b0;
      for (int i = 0; i < 5; i++) begin
         adc_valid = 1'b1;
         adc_data  = ADC_W'($urandom);
         @(posedge clk);
         #1;
      end
      check("pre_clr_write", fifo_in.write, 1'b1);
      ext_rst   = 1'b1;
      adc_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("clr_write", fifo_in.write, 1'b0);
      check("clr_busy", busy, 1'b0);
      check("clr_evt_cnt", evt_cnt, 16'h0);
      check("clr_ovf", ovf, 1'b0);
      ext_rst     = 1'b0;
      stall_force = 1'b0;
      exp_cnt     = '0;
      exp_ovf     = 1'b0;
      repeat (2) @(posedge clk);
      for (int i = 0; i < NSAMP; i++) smp[i] = ADC_W'($urandom);
      run_event(100, 1'b0, 0, NW);

      // Counter wrap
      force dut.evt_cnt = 16'hFFFF;
      @(posedge clk);
      #1;
      release dut.evt_cnt;
      @(negedge clk);
      check("preload_evt_cnt", evt_cnt, 16'hFFFF);
      exp_cnt = 16'hFFFF;
      for (int i = 0; i < NSAMP; i++) smp[i] = ADC_W'($urandom);
      run_event(100, 1'b0, 0, NW);
      check("wrap_evt_cnt", evt_cnt, 16'h0000);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
